// File: rtl/instr_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam int          ERR_MISALIGN = 0;
    localparam int          ERR_RANGE    = 1;
    localparam int          CNT_W        = 4;

endpackage

// File: rtl/instr_fetch_responder_store.sv
// Instruction store: one synchronous write port and one combinational read port, not reset.
module instr_store
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read sees the array before any same-edge write, so the capture gets the old word.
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder end of the instruction-fetch path: one outstanding word fetch,
// fixed wait states, flushable, with a preload port into the store.
module instr_fetch_responder
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic [1:0]                     rsp_err,
    input  logic                           flush,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data
);

    localparam int               IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0]      SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(WAIT_CYCLES);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q;
    logic [31:0]      rsp_instr_q, rsp_addr_q;
    logic [1:0]       rsp_err_q;

    logic             accept;
    logic             enter_resp;
    logic [31:0]      fetch_addr;
    logic [31:0]      fetch_off;
    logic [1:0]       fetch_err;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      store_word;

    instr_store #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (ld_en),
        .wr_idx_i  (ld_idx),
        .wr_data_i (ld_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (store_word)
    );

    assign accept = req_valid & req_ready;

    // With zero wait states RESP is entered straight from IDLE, so look up the live request.
    assign fetch_addr              = (state_q == IDLE) ? req_addr : addr_q;
    assign fetch_off               = fetch_addr - BASE_ADDR;
    assign fetch_err[ERR_MISALIGN] = |fetch_addr[1:0];
    assign fetch_err[ERR_RANGE]    = (fetch_off >= SPAN_BYTES);
    assign rd_idx                  = fetch_off[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = rstn & (state_q == IDLE) & ~flush;
        rsp_valid = (state_q == RESP);
    end

    assign enter_resp = (state_q != RESP) && (state_d == RESP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q      <= '0;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
            end
            if (enter_resp) begin
                rsp_addr_q  <= fetch_addr;
                rsp_err_q   <= fetch_err;
                rsp_instr_q <= (fetch_err == 2'b00) ? store_word : NOP;
            end
        end
    end

    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: two instances (1 and 0 wait states) checked every cycle against a timing model.
module tb_instr_fetch_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn, req_valid, rsp_ready, flush, ld_en;
    logic [31:0] req_addr, ld_data;
    logic [3:0]  ld_idx;

    logic [1:0]       rr, rv;
    logic [1:0][31:0] ri, ra;
    logic [1:0][1:0]  re;

    always #5 clk = ~clk;

    instr_fetch_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_w1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_instr(ri[0]), .rsp_addr(ra[0]), .rsp_err(re[0]),
        .flush(flush), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    instr_fetch_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) u_w0 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_instr(ri[1]), .rsp_addr(ra[1]), .rsp_err(re[1]),
        .flush(flush), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    // Reference model: each instance holds at most one fetch, visible from cycle accept+1+wait.
    logic [31:0] mmem [DEPTH];
    bit          m_pend  [2];
    bit          m_fresh [2];
    int          m_due   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_raddr [2];
    logic [1:0]  m_err   [2];
    int          cyc = 0;
    bit          armed = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'h0000_1000;
    endfunction

    function automatic void chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s u%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
        end
    endfunction

    function automatic void resolve(input int i);
        logic [31:0] off;
        logic [1:0]  err;
        off    = m_addr[i] - base_of(i);
        err[0] = (m_addr[i][1:0] != 2'b00);
        err[1] = (off >= 32'(DEPTH * 4));
        m_instr[i] = (err == 2'b00) ? mmem[off[5:2]] : NOPW;
        m_raddr[i] = m_addr[i];
        m_err[i]   = err;
        m_fresh[i] = 1'b0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rstn) armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_pend[i]  = 1'b0;
                m_fresh[i] = 1'b1;
                m_instr[i] = '0;
                m_raddr[i] = '0;
                m_err[i]   = '0;
            end else if (m_pend[i]) begin
                if (flush) begin
                    m_pend[i]  = 1'b0;
                    m_fresh[i] = 1'b0;
                end else if (cyc >= m_due[i]) begin
                    if (rsp_ready) m_pend[i] = 1'b0;
                end else if (cyc + 1 == m_due[i]) begin
                    resolve(i);
                end
            end else if (req_valid && !flush) begin
                m_pend[i] = 1'b1;
                m_due[i]  = cyc + 1 + wait_of(i);
                m_addr[i] = req_addr;
                if (cyc + 1 == m_due[i]) resolve(i);
            end
        end
        if (ld_en) mmem[ld_idx] = ld_data;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic ev;
                ev = m_pend[i] && (cyc >= m_due[i]);
                chk("req_ready", i, 32'(rr[i]), 32'(rstn && !m_pend[i] && !flush));
                chk("rsp_valid", i, 32'(rv[i]), 32'(ev));
                if (ev || m_fresh[i]) begin
                    chk("rsp_instr", i, ri[i], m_instr[i]);
                    chk("rsp_addr", i, ra[i], m_raddr[i]);
                    chk("rsp_err", i, 32'(re[i]), 32'(m_err[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_req(input logic [31:0] a, output int t_acc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!rr[0] && n < 50) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("accept", 0, 32'(rr[0]), 32'd1);
        t_acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!rv[0] && n < 50) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("rsp_arrives", 0, 32'(rv[0]), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ee);
        int t0;
        accept_req(a, t0);
        wait_rsp();
        chk("latency", 0, 32'(cyc - t0), 32'd2);
        chk("lit_instr", 0, ri[0], ei);
        chk("lit_addr", 0, ra[0], a);
        chk("lit_err", 0, 32'(re[0]), 32'(ee));
        tick();
    endtask

    logic [31:0] prog [DEPTH];
    int          t_acc;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
        ld_en = 1'b0; req_addr = '0; ld_idx = '0; ld_data = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 0, 32'(rr[0]), 32'd0);
        chk("rst_valid", 0, 32'(rv[0]), 32'd0);
        chk("rst_instr", 0, ri[0], 32'd0);
        tick();
        rstn = 1'b1;

        prog[0] = 32'h0050_0093; prog[1] = 32'h0010_8113;
        prog[2] = 32'h0020_81b3; prog[3] = 32'h0000_0013;
        for (int k = 4; k < DEPTH; k++) prog[k] = $urandom;
        prog[5] = 32'h00a0_0513;
        for (int k = 0; k < DEPTH; k++) begin
            ld_en = 1'b1; ld_idx = 4'(k); ld_data = prog[k];
            tick();
        end
        ld_en = 1'b0;

        fetch(32'h0, 32'h0050_0093, 2'b00);
        fetch(32'h4, 32'h0010_8113, 2'b00);
        fetch(32'h8, 32'h0020_81b3, 2'b00);
        fetch(32'h6, NOPW, 2'b01);
        fetch(32'h40, NOPW, 2'b10);
        fetch(32'hFFFF_FFFE, NOPW, 2'b11);

        // Consumer stalls for five cycles in RESP.
        rsp_ready = 1'b0;
        accept_req(32'h4, t_acc);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 0, 32'(rv[0]), 32'd1);
            chk("hold_ready", 0, 32'(rr[0]), 32'd0);
            chk("hold_instr", 0, ri[0], 32'h0010_8113);
            tick();
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("after_hold_ready", 0, 32'(rr[0]), 32'd1);
        tick();

        // Flush during WAIT abandons the fetch.
        accept_req(32'h8, t_acc);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flushed_no_rsp", 0, 32'(rv[0]), 32'd0);
            tick();
        end
        fetch(32'h4, 32'h0010_8113, 2'b00);

        // Reset while holding a response.
        rsp_ready = 1'b0;
        accept_req(32'h8, t_acc);
        wait_rsp();
        chk("pre_rst_instr", 0, ri[0], 32'h0020_81b3);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rstlow_ready", 0, 32'(rr[0]), 32'd0);
        tick();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 0, 32'(rv[0]), 32'd0);
        chk("midrst_instr", 0, ri[0], 32'd0);
        chk("midrst_addr", 0, ra[0], 32'd0);
        chk("midrst_err", 0, 32'(re[0]), 32'd0);
        chk("midrst_ready", 0, 32'(rr[0]), 32'd1);
        tick();

        // Zero wait states, store write on the same edge that captures the response.
        repeat (3) tick();
        req_valid = 1'b1; req_addr = 32'h0000_1014;
        ld_en = 1'b1; ld_idx = 4'd5; ld_data = 32'hdead_beef;
        @(negedge clk);
        chk("w0_accept", 1, 32'(rr[1]), 32'd1);
        tick();
        req_valid = 1'b0; ld_en = 1'b0;
        @(negedge clk);
        chk("w0_latency", 1, 32'(rv[1]), 32'd1);
        chk("w0_old_word", 1, ri[1], 32'h00a0_0513);
        chk("w0_addr", 1, ra[1], 32'h0000_1014);
        tick();
        req_valid = 1'b1;
        @(negedge clk);
        chk("w0_accept2", 1, 32'(rr[1]), 32'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("w0_new_word", 1, ri[1], 32'hdead_beef);
        tick();

        // Randomised traffic, checked by the per-cycle compare.
        for (int k = 0; k < 3000; k++) begin
            rstn      = ($urandom % 200) != 0;
            req_valid = $urandom % 2;
            flush     = ($urandom % 16) == 0;
            rsp_ready = ($urandom % 4) != 0;
            ld_en     = ($urandom % 8) == 0;
            ld_idx    = 4'($urandom % 16);
            ld_data   = $urandom;
            case ($urandom % 4)
                0: req_addr = 32'($urandom % 16) * 4;
                1: req_addr = 32'h0000_1000 + 32'($urandom % 20) * 4;
                2: req_addr = $urandom;
                default: req_addr = 32'h0000_1000 * 32'($urandom % 2) + 32'($urandom % 96);
            endcase
            tick();
        end
        rstn = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1; ld_en = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
